// File: rtl/riscvibe_pkg.sv
// Shared types for the data-memory load/store path: access width encodings
// (funct3 values), load/store unit state encoding and a width legality helper.
package riscvibe_pkg;

  typedef enum logic [2:0] {
    MEM_BYTE   = 3'b000,
    MEM_HALF   = 3'b001,
    MEM_WORD   = 3'b010,
    MEM_BYTE_U = 3'b100,
    MEM_HALF_U = 3'b101
  } mem_width_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    WAIT_LO  = 3'd2,
    ISSUE_HI = 3'd3,
    WAIT_HI  = 3'd4,
    DONE     = 3'd5
  } lsu_state_e;

  function automatic logic width_legal(input logic [2:0] width);
    case (width)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store data spread over two
// words, and the shift/extend of a two-word load window into one result.
module lsu_align import riscvibe_pkg::*; (
  input  logic [1:0]  off,
  input  logic [2:0]  width,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [7:0]  be8,
  output logic [63:0] w64,
  output logic [31:0] rdata
);

  logic [3:0]  mask_s;
  logic [63:0] r64_s;
  logic [31:0] r_s;
  logic        unused_r64_s;

  // Byte mask of the access before it is shifted to its lane offset
  always_comb begin
    mask_s = 4'b0000;
    case (width)
      MEM_BYTE, MEM_BYTE_U: mask_s = 4'b0001;
      MEM_HALF, MEM_HALF_U: mask_s = 4'b0011;
      MEM_WORD:             mask_s = 4'b1111;
      default:              mask_s = 4'b0000;
    endcase
  end

  assign be8          = {4'b0000, mask_s} << off;
  assign w64          = {32'h0000_0000, wdata} << {off, 3'b000};
  assign r64_s        = {hi_word, lo_word} >> {off, 3'b000};
  assign r_s          = r64_s[31:0];
  assign unused_r64_s = ^r64_s[63:32];

  // Sign or zero extension of the shifted load data
  always_comb begin
    rdata = 32'h0000_0000;
    case (width)
      MEM_BYTE:   rdata = {{24{r_s[7]}}, r_s[7:0]};
      MEM_HALF:   rdata = {{16{r_s[15]}}, r_s[15:0]};
      MEM_WORD:   rdata = r_s;
      MEM_BYTE_U: rdata = {24'h00_0000, r_s[7:0]};
      MEM_HALF_U: rdata = {16'h0000, r_s[15:0]};
      default:    rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: accepts one core access, issues one
// or two word transactions on a req/gnt/rvalid port, returns one response.
module load_store_unit import riscvibe_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [2:0]        req_width,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_r, state_next;
  logic [ADDR_W-1:0] addr_r;
  logic              write_r;
  logic [2:0]        width_r;
  logic [31:0]       wdata_r, lo_word_r, hi_word_r;

  logic [ADDR_W-1:0] base_addr_s, lo_addr_s, hi_addr_s;
  logic [1:0]        off_s;
  logic [2:0]        width_s;
  logic [31:0]       wdata_s, lo_in_s, hi_in_s, ext_s;
  logic [7:0]        be8_s;
  logic [63:0]       w64_s;
  logic              split_s;

  // In IDLE the aligner looks at the incoming request so the first
  // transaction can be registered on the accept edge.
  always_comb begin
    base_addr_s = addr_r;
    width_s     = width_r;
    wdata_s     = wdata_r;
    if (state_r == IDLE) begin
      base_addr_s = req_addr;
      width_s     = req_width;
      wdata_s     = req_wdata;
    end else begin
      base_addr_s = addr_r;
      width_s     = width_r;
      wdata_s     = wdata_r;
    end
    lo_in_s = lo_word_r;
    hi_in_s = hi_word_r;
    if (state_r == WAIT_LO) begin
      lo_in_s = mem_rdata;
    end else if (state_r == WAIT_HI) begin
      hi_in_s = mem_rdata;
    end else begin
      lo_in_s = lo_word_r;
      hi_in_s = hi_word_r;
    end
  end

  assign off_s     = base_addr_s[1:0];
  assign lo_addr_s = {base_addr_s[ADDR_W-1:2], 2'b00};
  assign hi_addr_s = {base_addr_s[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};
  assign split_s   = |be8_s[7:4];
  assign req_ready = (state_r == IDLE);

  lsu_align u_align (
    .off     (off_s),
    .width   (width_s),
    .wdata   (wdata_s),
    .lo_word (lo_in_s),
    .hi_word (hi_in_s),
    .be8     (be8_s),
    .w64     (w64_s),
    .rdata   (ext_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next;
  end

  // Next-state logic; rvalid only counts while waiting on a granted request
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) state_next = width_legal(req_width) ? ISSUE_LO : DONE;
        else           state_next = IDLE;
      end
      ISSUE_LO: state_next = mem_gnt ? WAIT_LO : ISSUE_LO;
      WAIT_LO: begin
        if (mem_rvalid) state_next = split_s ? ISSUE_HI : DONE;
        else            state_next = WAIT_LO;
      end
      ISSUE_HI: state_next = mem_gnt ? WAIT_HI : ISSUE_HI;
      WAIT_HI:  state_next = mem_rvalid ? DONE : WAIT_HI;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Request latch and captured read words
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r    <= '0;
      write_r   <= 1'b0;
      width_r   <= 3'b000;
      wdata_r   <= 32'h0000_0000;
      lo_word_r <= 32'h0000_0000;
      hi_word_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r    <= req_addr;
            write_r   <= req_write;
            width_r   <= req_width;
            wdata_r   <= req_wdata;
            lo_word_r <= 32'h0000_0000;
            hi_word_r <= 32'h0000_0000;
          end
        end
        WAIT_LO: if (mem_rvalid) lo_word_r <= mem_rdata;
        WAIT_HI: if (mem_rvalid) hi_word_r <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Memory port; fields only change when a new transaction is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
    end else begin
      mem_req <= (state_next == ISSUE_LO) || (state_next == ISSUE_HI);
      if (state_r == IDLE && state_next == ISSUE_LO) begin
        mem_addr  <= lo_addr_s;
        mem_we    <= req_write;
        mem_be    <= be8_s[3:0];
        mem_wdata <= w64_s[31:0];
      end else if (state_r == WAIT_LO && state_next == ISSUE_HI) begin
        mem_addr  <= hi_addr_s;
        mem_we    <= write_r;
        mem_be    <= be8_s[7:4];
        mem_wdata <= w64_s[63:32];
      end
    end
  end

  // Response registers; rdata/err hold until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else if (state_next == DONE) begin
      rsp_valid <= 1'b1;
      rsp_err   <= (state_r == IDLE);
      rsp_rdata <= (state_r == IDLE || write_r) ? 32'h0000_0000 : ext_s;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
